// File: rtl/shared_bus_arbiter.sv
// Round-robin owner for an internal shared bus. It issues registered one-hot grants
// with a bounded hold, inserts a dead gap between owners, and drives a registered AND-OR bus.
module shared_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   din,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        bus_valid,
  output logic [DATA_W-1:0]           bus_dout,
  output logic [$clog2(NUM_REQ)-1:0]  bus_owner
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_LAST = (TURNAROUND > 0) ? TW'(TURNAROUND - 1) : '0;
  localparam logic [OW-1:0] PTR_RST   = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [OW-1:0]       ptr_q, ptr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [TW-1:0]       turn_q, turn_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  logic                beat_s;
  logic [DATA_W-1:0]   owner_data_s;
  logic                any_s, hi_found_s, arb_s;
  logic [OW-1:0]       low_s, hi_s, pick_s;

  // AND-OR bus: only the granted and requesting source contributes, so no contention is possible.
  always_comb begin
    owner_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_data_s = owner_data_s | (din[i*DATA_W +: DATA_W] & {DATA_W{gnt_q[i] & req[i]}});
    end
    beat_s = |(gnt_q & req);
  end

  // Round-robin pick. Prefer the lowest request above the pointer, otherwise wrap to the lowest overall.
  always_comb begin
    any_s      = 1'b0;
    hi_found_s = 1'b0;
    low_s      = '0;
    hi_s       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_s = 1'b1;
        low_s = OW'(i);
        if (OW'(i) > ptr_q) begin
          hi_found_s = 1'b1;
          hi_s       = OW'(i);
        end
      end
    end
    pick_s = hi_found_s ? hi_s : low_s;
  end

  // Next-state logic and registered outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    valid_d = beat_s;
    dout_d  = owner_data_s;
    arb_s   = 1'b0;
    case (state_q)
      IDLE: arb_s = 1'b1;
      GRANT: begin
        if (beat_s) begin
          hold_d = hold_q + HW'(1);
        end else begin
          hold_d = hold_q;
        end
        // A dropped request and the hold limit reached together give one release.
        if (!beat_s || (hold_q + HW'(1) == HOLD_LAST)) begin
          gnt_d   = '0;
          owner_d = '0;
          hold_d  = '0;
          if (TURNAROUND == 0) begin
            arb_s = 1'b1;
          end else begin
            state_d = TURN;
            turn_d  = '0;
          end
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          arb_s = 1'b1;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb_s) begin
      if (any_s) begin
        state_d = GRANT;
        gnt_d   = NUM_REQ'(1) << pick_s;
        owner_d = pick_s;
        ptr_d   = pick_s;
        hold_d  = '0;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      hold_q  <= '0;
      turn_q  <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

  assign gnt       = gnt_q;
  assign bus_owner = owner_q;
  assign bus_valid = valid_q;
  assign bus_dout  = dout_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter (4 sources, 8-bit data, hold 4, one-cycle gap).
// Each test starts from reset, and cycle 0 is the first cycle after reset is released.
module tb_shared_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic        bus_valid;
  logic [7:0]  bus_dout;
  logic [1:0]  bus_owner;

  int n_tests = 0;
  int n_fail  = 0;

  shared_bus_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4), .TURNAROUND(1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .din(din),
    .gnt(gnt), .bus_valid(bus_valid), .bus_dout(bus_dout), .bus_owner(bus_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    din   = 32'h0;
    tick();
    reset = 1'b0;
  endtask

  logic [3:0]  prev_gnt;
  logic [3:0]  prev_req;
  logic [31:0] prev_din;
  logic [1:0]  prev_owner;
  logic        exp_valid;
  logic [7:0]  exp_dout;
  logic [3:0]  exp_gnt;
  int          k;

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    din   = 32'h0;
    #2;
    check_val("rst_gnt", {28'h0, gnt}, 32'h0);
    check_val("rst_valid", {31'h0, bus_valid}, 32'h0);
    check_val("rst_dout", {24'h0, bus_dout}, 32'h0);
    check_val("rst_owner", {30'h0, bus_owner}, 32'h0);
    tick();
    reset = 1'b0;

    // Single source 1
    req = 4'b0010;
    tick();
    check_val("s1_gnt_c1", {28'h0, gnt}, 32'h2);
    check_val("s1_owner_c1", {30'h0, bus_owner}, 32'h1);
    check_val("s1_valid_c1", {31'h0, bus_valid}, 32'h0);
    din[15:8] = 8'hA5;
    tick();
    check_val("s1_dout_c2", {23'h0, bus_valid, bus_dout}, 32'h1A5);
    din[15:8] = 8'hA6;
    tick();
    check_val("s1_dout_c3", {23'h0, bus_valid, bus_dout}, 32'h1A6);
    din[15:8] = 8'hA7;
    tick();
    check_val("s1_gnt_c4", {28'h0, gnt}, 32'h2);
    check_val("s1_dout_c4", {23'h0, bus_valid, bus_dout}, 32'h1A7);
    req = 4'b0000;
    tick();
    check_val("s1_gnt_c5", {28'h0, gnt}, 32'h0);
    check_val("s1_dout_c5", {23'h0, bus_valid, bus_dout}, 32'h0);
    tick();
    check_val("s1_gnt_c6", {28'h0, gnt}, 32'h0);
    check_val("s1_owner_c6", {30'h0, bus_owner}, 32'h0);
    check_val("s1_dout_c6", {23'h0, bus_valid, bus_dout}, 32'h0);

    // Saturation: the expected window pattern is 4 grant cycles, then 1 gap, rotating owners 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    din = 32'hC3C2C1C0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      exp_gnt = ((c - 1) % 5 < 4) ? (4'b0001 << (((c - 1) / 5) % 4)) : 4'b0000;
      exp_valid = (c >= 2) && ((c - 2) % 5 < 4);
      exp_dout = exp_valid ? (8'hC0 | 8'(((c - 2) / 5) % 4)) : 8'h00;
      check_val($sformatf("sat_gnt_c%0d", c), {28'h0, gnt}, {28'h0, exp_gnt});
      check_val($sformatf("sat_bus_c%0d", c), {23'h0, bus_valid, bus_dout}, {23'h0, exp_valid, exp_dout});
    end

    // Fairness: after owner 2, source 3 must come before source 0
    do_reset();
    req = 4'b0100;
    tick();
    check_val("fair_gnt_c1", {28'h0, gnt}, 32'h4);
    req = 4'b1101;
    tick();
    req = 4'b1001;
    tick();
    check_val("fair_gnt_c3", {28'h0, gnt}, 32'h0);
    tick();
    check_val("fair_gnt_c4", {28'h0, gnt}, 32'h8);
    check_val("fair_owner_c4", {30'h0, bus_owner}, 32'h3);
    req = 4'b0001;
    tick();
    check_val("fair_gnt_c5", {28'h0, gnt}, 32'h0);
    tick();
    check_val("fair_gnt_c6", {28'h0, gnt}, 32'h1);

    // Boundary: req drops as the 4th beat appears on the bus
    do_reset();
    req = 4'b0001;
    din = 32'h00000077;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_val($sformatf("bnd_gnt_c%0d", c), {28'h0, gnt}, 32'h1);
    end
    tick();
    req = 4'b0000;
    check_val("bnd_gnt_c5", {28'h0, gnt}, 32'h0);
    check_val("bnd_bus_c5", {23'h0, bus_valid, bus_dout}, 32'h177);
    tick();
    check_val("bnd_gnt_c6", {28'h0, gnt}, 32'h0);
    check_val("bnd_bus_c6", {23'h0, bus_valid, bus_dout}, 32'h0);
    req = 4'b0001;
    tick();
    check_val("bnd_gnt_c7", {28'h0, gnt}, 32'h1);

    // Reset asserted during source 2's second beat
    do_reset();
    req = 4'b0100;
    din = 32'h00550000;
    tick();
    tick();
    check_val("rmg_bus_pre", {23'h0, bus_valid, bus_dout}, 32'h155);
    reset = 1'b1;
    #1;
    check_val("rmg_gnt", {28'h0, gnt}, 32'h0);
    check_val("rmg_bus", {23'h0, bus_valid, bus_dout}, 32'h0);
    req = 4'b0101;
    tick();
    reset = 1'b0;
    tick();
    check_val("rmg_gnt_after", {28'h0, gnt}, 32'h1);

    // Random requests: check the invariants every cycle
    do_reset();
    for (int c = 0; c < 300; c++) begin
      req = 4'($urandom);
      din = $urandom;
      prev_gnt   = gnt;
      prev_owner = bus_owner;
      prev_req   = req;
      prev_din   = din;
      tick();
      exp_valid = (prev_gnt != 4'b0000) && ((prev_gnt & prev_req) != 4'b0000);
      k = 0;
      for (int i = 0; i < 4; i++) if (prev_gnt[i]) k = i;
      exp_dout = exp_valid ? prev_din[k*8 +: 8] : 8'h00;
      check_val("rnd_onehot", {31'h0, $countones(gnt) <= 1}, 32'h1);
      check_val("rnd_bus", {23'h0, bus_valid, bus_dout}, {23'h0, exp_valid, exp_dout});
      check_val("rnd_owner", {31'h0, (gnt == 4'b0000) ? (bus_owner == 2'd0) : (gnt == (4'b0001 << bus_owner))}, 32'h1);
      check_val("rnd_adjacent", {31'h0, (prev_gnt == 4'b0000) || (gnt == 4'b0000) || (gnt == prev_gnt)}, 32'h1);
      check_val("rnd_prev_owner", {31'h0, (prev_gnt == 4'b0000) || (prev_gnt == (4'b0001 << prev_owner))}, 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_bus_arbiter.md
Name: shared_bus_arbiter

Overview:
- Owner side of an internal shared bus: decides which of NUM_REQ sources may drive the bus.
- Issues registered one-hot grants (driver enables) with round-robin fairness, a bounded hold time and a guaranteed dead (turnaround) gap between owners.
- Builds the bus as an AND-OR mux, so contention and floating values are impossible by construction.
- Feeds downstream registered consumers with bus_valid/bus_dout.

Parameters:
NUM_REQ, 4, number of requesting sources (>=2)
DATA_W, 8, bus data width
MAX_HOLD, 16, max beats per grant before forced release (>=1)
TURNAROUND, 1, dead cycles with no grant between owners (>=0)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
req  input  NUM_REQ  per-source bus request; held high while source has data
din  input  NUM_REQ*DATA_W  flattened source data, source i at [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  registered one-hot grant (driver enable), all-zero when no owner
bus_valid  output  1  registered: bus_dout carries a beat this cycle
bus_dout  output  DATA_W  registered bus data
bus_owner  output  clog2(NUM_REQ)  index of current owner, 0 when none

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset (async, immediate):
  - gnt=0, bus_valid=0, bus_dout=0, bus_owner=0.
  - State IDLE, hold count 0, turnaround count 0.
  - RR pointer = NUM_REQ-1, so source 0 has top priority first.
- States: IDLE, GRANT, TURN.
- Arbitration, evaluated in IDLE and in the last cycle of TURN:
  - If any req is high, pick the first high req scanning from pointer+1 upward, wrapping modulo NUM_REQ.
  - gnt[pick]=1 and bus_owner=pick at the next edge. Pointer <= pick. State -> GRANT, hold count 0.
  - Latency: req high in IDLE at cycle n -> gnt at cycle n+1.
- GRANT, owner o:
  - Beat = gnt[o] & req[o]. On a beat: bus_dout <= din[o], bus_valid <= 1 at the next edge (1-cycle latency), hold count +1.
  - Release when req[o]=0 in a grant cycle, or when a beat brings the hold count to MAX_HOLD.
  - On release, next edge: gnt=0, bus_owner=0, bus_valid=0, bus_dout=0. State -> TURN, or straight to arbitration-as-IDLE when TURNAROUND=0.
  - A simultaneous req drop and MAX_HOLD boundary produce a single release.
- TURN:
  - gnt=0 for exactly TURNAROUND cycles; arbitration runs in the final cycle.
  - The gap between consecutive grant windows is exactly TURNAROUND cycles.
  - If no req is pending at the end of TURN, state -> IDLE.
- bus_valid/bus_dout idle value: 0 whenever no beat occurred in the previous cycle. Never X.
- Invariant: popcount(gnt) <= 1 every cycle. No two owners in adjacent cycles when TURNAROUND>=1.
- req changes from non-owners during GRANT are ignored until the next arbitration.
- din of a non-owner never reaches bus_dout.
- Reset asserted mid-GRANT: grant dropped immediately, pointer restored to NUM_REQ-1, any partial burst discarded.

Test Plan:
- Config for all tests: NUM_REQ=4, DATA_W=8, MAX_HOLD=4, TURNAROUND=1.
- Single source: req[1] high cycles 0-3, din1=0xA5,0xA6,0xA7 at cycles 1-3 -> gnt=4'b0010 cycles 1-4, bus_owner=1; bus_valid cycles 2-4 with 0xA5,0xA6,0xA7; gnt=0 cycle 5; IDLE cycle 6; bus_dout=0 from cycle 5.
- Saturation: all req high from cycle 0 -> grants 0,1,2,3,0 in order, each gnt window exactly 4 cycles, exactly 1 zero-grant cycle between windows, 4 consecutive bus_valid beats per window.
- Fairness: owner 2 releases while req[0] and req[3] are pending -> next gnt=4'b1000 (source 3), then 4'b0001.
- Boundary: req[0] drops in the same cycle as the 4th beat -> one release, one TURN cycle, no extra beat, no double TURN.
- Reset mid-GRANT: assert reset during source 2's 2nd beat -> gnt, bus_valid, bus_dout all 0 immediately. After deassert with req[0] and req[2] high -> gnt=4'b0001 first.
- Invariant check every cycle of a random-req run: popcount(gnt)<=1, bus_valid implies the previous-cycle gnt matched bus_owner's source, and bus_dout==0 whenever bus_valid=0.
